riscv_stream_merger: RTL and testbench

//  Packet-atomic 2:1 AXI-Stream merger on the return path of the RISC-V offload.
//  - Joins the bypass data stream (s_axis_*) with the RISC-V response stream (c_s_axis_*)

---
 rtl/riscv_stream_merger.sv | 159 +++++++++++++++
 tb/tb_riscv_stream_merger.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_stream_merger.sv
// riscv_stream_merger
// Packet-atomic 2:1 AXI-Stream merger. The bypass data stream (s_axis_*) and the
// RISC-V response stream (c_s_axis_*) share one registered egress (m_axis_*).
// Once a source wins a packet it keeps the grant until that packet's tlast is taken.
//
//  state      | meaning
//  -----------+-------------------------------------------------------------
//  S_IDLE     | between packets; grant decided combinationally each cycle
//  S_FWD_DATA | inside a bypass packet; only s_axis may be accepted
//  S_FWD_CTL  | inside a RISC-V packet; only c_s_axis may be accepted
module riscv_stream_merger #(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int CTL_PRIORITY         = 0
) (
    input  logic                              clk,
    input  logic                              aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
    input  logic                              c_s_axis_tvalid,
    output logic                              c_s_axis_tready,
    input  logic                              c_s_axis_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic [31:0]                       data_pkt_cnt,
    output logic [31:0]                       ctl_pkt_cnt
);

    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FWD_DATA = 2'd1,
        S_FWD_CTL  = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_last_ctl;     // 1: last granted packet came from c_s_axis
    logic [DW-1:0]   r_m_tdata;
    logic [KW-1:0]   r_m_tkeep;
    logic [UW-1:0]   r_m_tuser;
    logic            r_m_tvalid;
    logic            r_m_tlast;
    logic [31:0]     r_data_pkt_cnt;
    logic [31:0]     r_ctl_pkt_cnt;

    logic            w_ld;
    logic            w_grant_ctl;
    logic            w_idle_any;
    logic            w_s_rdy;
    logic            w_c_rdy;
    logic            w_s_acc;
    logic            w_c_acc;
    logic            w_acc;
    logic            w_acc_last;

    // Output stage can take a new beat when empty or draining this cycle.
    assign w_ld = !r_m_tvalid || m_axis_tready;

    // Grant selection: locked inside a packet, arbitrated in IDLE.
    always_comb begin
        w_grant_ctl = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (s_axis_tvalid && c_s_axis_tvalid)
                    w_grant_ctl = (CTL_PRIORITY != 0) ? 1'b1 : !r_last_ctl;
                else
                    w_grant_ctl = c_s_axis_tvalid;
            end
            S_FWD_CTL: w_grant_ctl = 1'b1;
            default:   w_grant_ctl = 1'b0;
        endcase
    end

    assign w_idle_any = (r_state == S_IDLE) && (s_axis_tvalid || c_s_axis_tvalid);

    // Ready is held low while in reset so no beat is taken before the FSM is running.
    assign w_s_rdy = aresetn && w_ld && !w_grant_ctl && ((r_state == S_FWD_DATA) || w_idle_any);
    assign w_c_rdy = aresetn && w_ld &&  w_grant_ctl && ((r_state == S_FWD_CTL)  || w_idle_any);

    assign w_s_acc    = s_axis_tvalid   && w_s_rdy;
    assign w_c_acc    = c_s_axis_tvalid && w_c_rdy;
    assign w_acc      = w_s_acc || w_c_acc;
    assign w_acc_last = w_c_acc ? c_s_axis_tlast : s_axis_tlast;

    assign s_axis_tready   = w_s_rdy;
    assign c_s_axis_tready = w_c_rdy;

    // Egress register: loads the granted beat whenever the slot is free, holds otherwise.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tuser  <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
        end else if (w_ld) begin
            r_m_tvalid <= w_acc;
            r_m_tdata  <= w_grant_ctl ? c_s_axis_tdata : s_axis_tdata;
            r_m_tkeep  <= w_grant_ctl ? c_s_axis_tkeep : s_axis_tkeep;
            r_m_tuser  <= w_grant_ctl ? c_s_axis_tuser : s_axis_tuser;
            r_m_tlast  <= w_grant_ctl ? c_s_axis_tlast : s_axis_tlast;
        end
    end

    // Packet-lock FSM and round-robin history.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= S_IDLE;
            r_last_ctl <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_last_ctl <= w_grant_ctl;
                        if (!w_acc_last)
                            r_state <= w_grant_ctl ? S_FWD_CTL : S_FWD_DATA;
                    end
                end
                S_FWD_DATA: if (w_s_acc && s_axis_tlast)   r_state <= S_IDLE;
                S_FWD_CTL:  if (w_c_acc && c_s_axis_tlast) r_state <= S_IDLE;
                default:    r_state <= S_IDLE;
            endcase
        end
    end

    // Per-source packet counters, free-running modulo 2^32.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_data_pkt_cnt <= '0;
            r_ctl_pkt_cnt  <= '0;
        end else begin
            if (w_s_acc && s_axis_tlast)   r_data_pkt_cnt <= r_data_pkt_cnt + 32'd1;
            if (w_c_acc && c_s_axis_tlast) r_ctl_pkt_cnt  <= r_ctl_pkt_cnt + 32'd1;
        end
    end

    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tkeep  = r_m_tkeep;
    assign m_axis_tuser  = r_m_tuser;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tlast  = r_m_tlast;
    assign data_pkt_cnt  = r_data_pkt_cnt;
    assign ctl_pkt_cnt   = r_ctl_pkt_cnt;

endmodule

// File: tb/tb_riscv_stream_merger.sv
// Directed bench for riscv_stream_merger: a round-robin instance (u0) and a
// RISC-V-priority instance (u1) share the same input stimulus.
module tb_riscv_stream_merger;

    localparam int DW = 64;
    localparam int UW = 16;
    localparam int KW = DW / 8;

    typedef struct { logic [DW-1:0] d; logic l; } beat_t;
    typedef struct { logic [DW-1:0] d; logic [KW-1:0] k; logic [UW-1:0] u; logic l; } obeat_t;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] s_tdata, c_tdata;
    logic [KW-1:0] s_tkeep, c_tkeep;
    logic [UW-1:0] s_tuser, c_tuser;
    logic          s_tvalid, s_tlast, c_tvalid, c_tlast, m_tready;

    logic [DW-1:0] m0_tdata, m1_tdata;
    logic [KW-1:0] m0_tkeep, m1_tkeep;
    logic [UW-1:0] m0_tuser, m1_tuser;
    logic          m0_tvalid, m1_tvalid, m0_tlast, m1_tlast;
    logic          s0_trdy, s1_trdy, c0_trdy, c1_trdy;
    logic [31:0]   d0_cnt, d1_cnt, k0_cnt, k1_cnt;

    riscv_stream_merger #(.C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW), .CTL_PRIORITY(0)) u0 (
        .clk(clk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s0_trdy), .s_axis_tlast(s_tlast),
        .c_s_axis_tdata(c_tdata), .c_s_axis_tkeep(c_tkeep), .c_s_axis_tuser(c_tuser),
        .c_s_axis_tvalid(c_tvalid), .c_s_axis_tready(c0_trdy), .c_s_axis_tlast(c_tlast),
        .m_axis_tdata(m0_tdata), .m_axis_tkeep(m0_tkeep), .m_axis_tuser(m0_tuser),
        .m_axis_tvalid(m0_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m0_tlast),
        .data_pkt_cnt(d0_cnt), .ctl_pkt_cnt(k0_cnt));

    riscv_stream_merger #(.C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW), .CTL_PRIORITY(1)) u1 (
        .clk(clk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s1_trdy), .s_axis_tlast(s_tlast),
        .c_s_axis_tdata(c_tdata), .c_s_axis_tkeep(c_tkeep), .c_s_axis_tuser(c_tuser),
        .c_s_axis_tvalid(c_tvalid), .c_s_axis_tready(c1_trdy), .c_s_axis_tlast(c_tlast),
        .m_axis_tdata(m1_tdata), .m_axis_tkeep(m1_tkeep), .m_axis_tuser(m1_tuser),
        .m_axis_tvalid(m1_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m1_tlast),
        .data_pkt_cnt(d1_cnt), .ctl_pkt_cnt(k1_cnt));

    // The instance under observation is picked by use_prio.
    logic use_prio = 1'b0;
    wire          w_s_trdy  = use_prio ? s1_trdy   : s0_trdy;
    wire          w_c_trdy  = use_prio ? c1_trdy   : c0_trdy;
    wire          w_m_valid = use_prio ? m1_tvalid : m0_tvalid;
    wire [DW-1:0] w_m_data  = use_prio ? m1_tdata  : m0_tdata;
    wire [KW-1:0] w_m_keep  = use_prio ? m1_tkeep  : m0_tkeep;
    wire [UW-1:0] w_m_user  = use_prio ? m1_tuser  : m0_tuser;
    wire          w_m_last  = use_prio ? m1_tlast  : m0_tlast;
    wire [31:0]   w_d_cnt   = use_prio ? d1_cnt    : d0_cnt;
    wire [31:0]   w_k_cnt   = use_prio ? k1_cnt    : k0_cnt;

    int n_checks = 0;
    int n_errors = 0;

    beat_t  s_q[$], c_q[$], exp_q[$];
    obeat_t log_q[$];
    int     s_idx, c_idx;
    logic   hs_s, hs_c, s_en, c_en, m_rdy_nxt, s_trdy_seen;

    function automatic logic [KW-1:0] kf(logic [DW-1:0] d); return d[KW-1:0]; endfunction
    function automatic logic [UW-1:0] uf(logic [DW-1:0] d); return d[UW-1:0] ^ 16'hA5A5; endfunction
    function automatic beat_t mk(logic [DW-1:0] d, logic l);
        beat_t b; b.d = d; b.l = l; return b;
    endfunction

    // One clock: advance sources past last cycle's handshakes, drive, then sample at negedge.
    task automatic step();
        @(posedge clk); #1;
        if (hs_s) s_idx++;
        if (hs_c) c_idx++;
        m_tready = m_rdy_nxt;
        s_tvalid = s_en && (s_idx < s_q.size());
        c_tvalid = c_en && (c_idx < c_q.size());
        s_tdata = s_tvalid ? s_q[s_idx].d : '0;
        s_tlast = s_tvalid ? s_q[s_idx].l : 1'b0;
        c_tdata = c_tvalid ? c_q[c_idx].d : '0;
        c_tlast = c_tvalid ? c_q[c_idx].l : 1'b0;
        s_tkeep = kf(s_tdata); s_tuser = uf(s_tdata);
        c_tkeep = kf(c_tdata); c_tuser = uf(c_tdata);
        @(negedge clk);
        hs_s = s_tvalid && w_s_trdy;
        hs_c = c_tvalid && w_c_trdy;
        if (w_s_trdy && s_tvalid) s_trdy_seen = 1'b1;
        if (w_m_valid && m_tready) begin
            obeat_t o;
            o.d = w_m_data; o.k = w_m_keep; o.u = w_m_user; o.l = w_m_last;
            log_q.push_back(o);
        end
    endtask

    task automatic clear_stim();
        s_q.delete(); c_q.delete(); exp_q.delete(); log_q.delete();
        s_idx = 0; c_idx = 0; hs_s = 0; hs_c = 0; s_en = 0; c_en = 0;
        m_rdy_nxt = 1'b1; s_trdy_seen = 1'b0;
        s_tvalid = 0; c_tvalid = 0; s_tlast = 0; c_tlast = 0;
        s_tdata = '0; c_tdata = '0; s_tkeep = '0; c_tkeep = '0; s_tuser = '0; c_tuser = '0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        clear_stim();
        m_tready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        aresetn = 1'b1;
    endtask

    task automatic test_reset();
        use_prio = 1'b0;
        do_reset();
        n_checks++;
        if (m0_tvalid !== 1'b0 || m0_tdata !== '0 || m0_tkeep !== '0 || m0_tuser !== '0 || m0_tlast !== 1'b0) begin
            n_errors++; $display("FAIL reset_m0: got valid=%b data=%h last=%b, want all zero", m0_tvalid, m0_tdata, m0_tlast);
        end
        n_checks++;
        if (m1_tvalid !== 1'b0 || m1_tdata !== '0 || m1_tlast !== 1'b0) begin
            n_errors++; $display("FAIL reset_m1: got valid=%b data=%h, want all zero", m1_tvalid, m1_tdata);
        end
        n_checks++;
        if (d0_cnt !== 32'd0 || k0_cnt !== 32'd0 || s0_trdy !== 1'b0 || c0_trdy !== 1'b0) begin
            n_errors++; $display("FAIL reset_cnt_rdy: got dcnt=%0d kcnt=%0d srdy=%b crdy=%b, want 0", d0_cnt, k0_cnt, s0_trdy, c0_trdy);
        end
    endtask

    task automatic test_data_only();
        use_prio = 1'b0;
        do_reset();
        s_q.push_back(mk(64'h1111_0000_0000_0A01, 1'b0));
        s_q.push_back(mk(64'h2222_0000_0000_0B02, 1'b0));
        s_q.push_back(mk(64'h3333_0000_0000_0C03, 1'b1));
        s_en = 1'b1;
        step();
        n_checks++;
        if (w_s_trdy !== 1'b1 || w_m_valid !== 1'b0) begin
            n_errors++; $display("FAIL t1_first: got srdy=%b mvalid=%b, want 1/0", w_s_trdy, w_m_valid);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (w_m_valid !== 1'b1 || w_m_data !== s_q[i].d || w_m_last !== s_q[i].l ||
                w_m_keep !== kf(s_q[i].d) || w_m_user !== uf(s_q[i].d)) begin
                n_errors++; $display("FAIL t1_beat%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                    i, w_m_valid, w_m_data, w_m_last, s_q[i].d, s_q[i].l);
            end
        end
        n_checks++;
        if (w_d_cnt !== 32'd1 || w_k_cnt !== 32'd0) begin
            n_errors++; $display("FAIL t1_cnt: got data=%0d ctl=%0d, want 1/0", w_d_cnt, w_k_cnt);
        end
        step();
        n_checks++;
        if (w_m_valid !== 1'b0) begin
            n_errors++; $display("FAIL t1_drain: got mvalid=%b, want 0", w_m_valid);
        end
    endtask

    task automatic test_round_robin();
        use_prio = 1'b0;
        do_reset();
        s_q.push_back(mk(64'hD0, 1'b0)); s_q.push_back(mk(64'hD1, 1'b1));
        c_q.push_back(mk(64'hC0, 1'b0)); c_q.push_back(mk(64'hC1, 1'b1));
        exp_q.push_back(mk(64'hD0, 1'b0)); exp_q.push_back(mk(64'hD1, 1'b1));
        exp_q.push_back(mk(64'hC0, 1'b0)); exp_q.push_back(mk(64'hC1, 1'b1));
        s_en = 1'b1; c_en = 1'b1;
        repeat (6) step();
        n_checks++;
        if (log_q.size() != exp_q.size()) begin
            n_errors++; $display("FAIL t2_count: got %0d beats, want %0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_checks++;
            if (log_q[i].d !== exp_q[i].d || log_q[i].l !== exp_q[i].l ||
                log_q[i].k !== kf(exp_q[i].d) || log_q[i].u !== uf(exp_q[i].d)) begin
                n_errors++; $display("FAIL t2_beat%0d: got d=%h l=%b, want d=%h l=%b", i, log_q[i].d, log_q[i].l, exp_q[i].d, exp_q[i].l);
            end
        end
        n_checks++;
        if (w_d_cnt !== 32'd1 || w_k_cnt !== 32'd1) begin
            n_errors++; $display("FAIL t2_cnt: got data=%0d ctl=%0d, want 1/1", w_d_cnt, w_k_cnt);
        end
    endtask

    task automatic test_priority();
        use_prio = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++) c_q.push_back(mk(64'hC100 + 64'(i), 1'b1));
        for (int i = 0; i < 2; i++) s_q.push_back(mk(64'hD100 + 64'(i), 1'b1));
        s_en = 1'b1; c_en = 1'b1;
        repeat (3) step();
        n_checks++;
        if (s_trdy_seen !== 1'b0 || c_idx != 2 || hs_c !== 1'b1) begin
            n_errors++; $display("FAIL t3_starve: got srdy_seen=%b ctl_taken=%0d, want 0 and 3", s_trdy_seen, c_idx + (hs_c ? 1 : 0));
        end
        repeat (5) step();
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(64'hC100 + 64'(i), 1'b1));
        for (int i = 0; i < 2; i++) exp_q.push_back(mk(64'hD100 + 64'(i), 1'b1));
        n_checks++;
        if (log_q.size() != exp_q.size()) begin
            n_errors++; $display("FAIL t3_count: got %0d beats, want %0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_checks++;
            if (log_q[i].d !== exp_q[i].d || log_q[i].l !== exp_q[i].l) begin
                n_errors++; $display("FAIL t3_beat%0d: got d=%h, want d=%h", i, log_q[i].d, exp_q[i].d);
            end
        end
        n_checks++;
        if (w_k_cnt !== 32'd3 || w_d_cnt !== 32'd2) begin
            n_errors++; $display("FAIL t3_cnt: got ctl=%0d data=%0d, want 3/2", w_k_cnt, w_d_cnt);
        end
        use_prio = 1'b0;
    endtask

    task automatic test_backpressure();
        use_prio = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) s_q.push_back(mk(64'hBEEF_0000 + 64'(i), i == 3));
        c_q.push_back(mk(64'hCAFE, 1'b1));
        s_en = 1'b1;
        repeat (2) step();
        m_rdy_nxt = 1'b0; c_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (w_m_valid !== 1'b1 || w_m_data !== 64'hBEEF_0001 || w_m_last !== 1'b0 ||
                w_m_keep !== kf(64'hBEEF_0001) || w_m_user !== uf(64'hBEEF_0001) ||
                w_s_trdy !== 1'b0 || w_c_trdy !== 1'b0) begin
                n_errors++; $display("FAIL t4_stall%0d: got v=%b d=%h srdy=%b crdy=%b, want v=1 d=beef0001 rdy=0/0",
                    i, w_m_valid, w_m_data, w_s_trdy, w_c_trdy);
            end
        end
        m_rdy_nxt = 1'b1;
        repeat (6) step();
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(64'hBEEF_0000 + 64'(i), i == 3));
        exp_q.push_back(mk(64'hCAFE, 1'b1));
        n_checks++;
        if (log_q.size() != exp_q.size()) begin
            n_errors++; $display("FAIL t4_count: got %0d beats, want %0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_checks++;
            if (log_q[i].d !== exp_q[i].d || log_q[i].l !== exp_q[i].l) begin
                n_errors++; $display("FAIL t4_beat%0d: got d=%h l=%b, want d=%h l=%b", i, log_q[i].d, log_q[i].l, exp_q[i].d, exp_q[i].l);
            end
        end
    endtask

    task automatic test_ctl_gap();
        use_prio = 1'b0;
        do_reset();
        c_q.push_back(mk(64'hC50, 1'b0)); c_q.push_back(mk(64'hC51, 1'b0)); c_q.push_back(mk(64'hC52, 1'b1));
        s_q.push_back(mk(64'hD50, 1'b1));
        c_en = 1'b1;
        step();
        c_en = 1'b0; s_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (w_s_trdy !== 1'b0) begin
                n_errors++; $display("FAIL t5_gap%0d: got srdy=%b, want 0", i, w_s_trdy);
            end
        end
        c_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (w_s_trdy !== 1'b0 || w_c_trdy !== 1'b1) begin
                n_errors++; $display("FAIL t5_resume%0d: got srdy=%b crdy=%b, want 0/1", i, w_s_trdy, w_c_trdy);
            end
        end
        step();
        n_checks++;
        if (w_s_trdy !== 1'b1) begin
            n_errors++; $display("FAIL t5_release: got srdy=%b, want 1", w_s_trdy);
        end
        repeat (3) step();
        exp_q.push_back(mk(64'hC50, 1'b0)); exp_q.push_back(mk(64'hC51, 1'b0));
        exp_q.push_back(mk(64'hC52, 1'b1)); exp_q.push_back(mk(64'hD50, 1'b1));
        n_checks++;
        if (log_q.size() != exp_q.size()) begin
            n_errors++; $display("FAIL t5_count: got %0d beats, want %0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            n_checks++;
            if (log_q[i].d !== exp_q[i].d || log_q[i].l !== exp_q[i].l) begin
                n_errors++; $display("FAIL t5_beat%0d: got d=%h, want d=%h", i, log_q[i].d, exp_q[i].d);
            end
        end
    endtask

    task automatic test_wrap_and_reset();
        use_prio = 1'b0;
        do_reset();
        force u0.r_ctl_pkt_cnt = 32'hFFFF_FFFF;
        step();
        release u0.r_ctl_pkt_cnt;
        step();
        n_checks++;
        if (k0_cnt !== 32'hFFFF_FFFF) begin
            n_errors++; $display("FAIL t6_preload: got %h, want ffffffff", k0_cnt);
        end
        c_q.push_back(mk(64'hC60, 1'b1)); c_q.push_back(mk(64'hC61, 1'b1));
        c_en = 1'b1;
        repeat (2) step();
        n_checks++;
        if (k0_cnt !== 32'h0) begin
            n_errors++; $display("FAIL t6_wrap0: got %h, want 00000000", k0_cnt);
        end
        step();
        n_checks++;
        if (k0_cnt !== 32'h1) begin
            n_errors++; $display("FAIL t6_wrap1: got %h, want 00000001", k0_cnt);
        end
        repeat (2) step();
        c_en = 1'b0;
        s_q.push_back(mk(64'hD60, 1'b0)); s_q.push_back(mk(64'hD61, 1'b0)); s_q.push_back(mk(64'hD62, 1'b1));
        s_en = 1'b1;
        repeat (2) step();
        aresetn = 1'b0;
        #1;
        n_checks++;
        if (m0_tvalid !== 1'b0 || m0_tdata !== '0 || m0_tkeep !== '0 || m0_tuser !== '0 || m0_tlast !== 1'b0 ||
            s0_trdy !== 1'b0 || c0_trdy !== 1'b0 || d0_cnt !== 32'd0 || k0_cnt !== 32'd0) begin
            n_errors++; $display("FAIL t6_async_rst: got v=%b d=%h srdy=%b crdy=%b dcnt=%0d kcnt=%0d, want all 0",
                m0_tvalid, m0_tdata, s0_trdy, c0_trdy, d0_cnt, k0_cnt);
        end
        clear_stim();
        c_q.push_back(mk(64'hE60, 1'b1));
        c_en = 1'b1;
        @(negedge clk);
        aresetn = 1'b1;
        step();
        n_checks++;
        if (c0_trdy !== 1'b1 || s0_trdy !== 1'b0) begin
            n_errors++; $display("FAIL t6_idle_after_rst: got crdy=%b srdy=%b, want 1/0", c0_trdy, s0_trdy);
        end
        step();
        n_checks++;
        if (m0_tvalid !== 1'b1 || m0_tdata !== 64'hE60 || m0_tlast !== 1'b1) begin
            n_errors++; $display("FAIL t6_first_after_rst: got v=%b d=%h l=%b, want 1/e60/1", m0_tvalid, m0_tdata, m0_tlast);
        end
    endtask

    initial begin
        clear_stim();
        m_tready = 1'b1;
        test_reset();
        test_data_only();
        test_round_robin();
        test_priority();
        test_backpressure();
        test_ctl_gap();
        test_wrap_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
